// File: rtl/fp_mul_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_round_norm
// Function : FP32 multiplier back-end: normalise, RNE round, range/special pack
// Revision : 1.0
// ============================================================================
module fp_mul_round_norm #(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out,
    output logic [3:0]       out_flags
);

    localparam logic signed [EXP_W+1:0] C_EXP_MAX = (EXP_W+2)'(255);
    localparam logic signed [EXP_W+1:0] C_EXP_MIN = '0;

    // Stage 1 registers (normalised significand, stored without hidden bit)
    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W:0]   r_s1_exp;
    logic [22:0]      r_s1_frac;
    logic             r_s1_g;
    logic             r_s1_s;
    logic             r_s1_zero;
    logic             r_s1_inf;
    logic             r_s1_nan;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic [31:0]      r_out;
    logic [3:0]       r_flags;

    logic                    w_s1_adv;
    logic                    w_in_fire;
    logic [EXP_W:0]          w_s1_exp;
    logic                    w_round_up;
    logic [23:0]             w_rnd;
    logic signed [EXP_W+1:0] w_exp_rnd;
    logic [31:0]             w_res;
    logic [3:0]              w_flags;

    assign w_s1_adv  = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_fire = in_valid && in_ready;

    assign w_s1_exp = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, in_mant[47]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_s1_exp;
                r_s1_frac <= in_mant[47] ? in_mant[46:24] : in_mant[45:23];
                r_s1_g    <= in_mant[47] ? in_mant[23] : in_mant[22];
                r_s1_s    <= in_mant[47] ? (|in_mant[22:0]) : (|in_mant[21:0]);
                r_s1_zero <= in_zero;
                r_s1_inf  <= in_inf;
                r_s1_nan  <= in_nan;
            end
        end
    end

    // The hidden bit is always 1, so a carry out of the 23-bit fraction is
    // exactly the significand wrapping to 2.0; the fraction is then zero.
    assign w_round_up = r_s1_g && (r_s1_s || r_s1_frac[0]);
    assign w_rnd      = {1'b0, r_s1_frac} + {23'd0, w_round_up};
    assign w_exp_rnd  = {r_s1_exp[EXP_W], r_s1_exp} + {{(EXP_W+1){1'b0}}, w_rnd[23]};

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (r_s1_nan) begin
            w_res = QNAN;
        end else if (r_s1_inf && r_s1_zero) begin
            w_res   = QNAN;
            w_flags = 4'b1000;
        end else if (r_s1_inf) begin
            w_res = {r_s1_sign, 8'hFF, 23'd0};
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, 31'd0};
        end else if (w_exp_rnd >= C_EXP_MAX) begin
            w_res   = {r_s1_sign, 8'hFF, 23'd0};
            w_flags = 4'b0101;
        end else if (w_exp_rnd <= C_EXP_MIN) begin
            w_res   = {r_s1_sign, 31'd0};
            w_flags = 4'b0011;
        end else begin
            w_res   = {r_s1_sign, w_exp_rnd[7:0], w_rnd[22:0]};
            w_flags = {3'b000, r_s1_g || r_s1_s};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_flags     <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_flags     <= w_flags;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_round_norm
// Function : Scoreboard bench for fp_mul_round_norm with directed vectors
// Revision : 1.0
// ============================================================================
module tb_fp_mul_round_norm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  out_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
        bit          lat;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   tag_cnt  = 0;

    fp_mul_round_norm #(.EXP_W(10), .QNAN(32'h7FC00000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_zero   (in_zero),
        .in_inf    (in_inf),
        .in_nan    (in_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: values seen at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                if (out_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got out=%h flags=%b", out, out_flags);
                end
            end else begin
                e = q[0];
                checks++;
                if (out !== e.res || out_flags !== e.flg) begin
                    failures++;
                    $display("FAIL %s tag=%0d got out=%h flags=%b expected out=%h flags=%b",
                             out_ready ? "result" : "stall_hold", e.tag, out, out_flags, e.res, e.flg);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.lat) begin
                        checks++;
                        if ((cyc + 1) - e.acc != 2) begin
                            failures++;
                            $display("FAIL latency tag=%0d got=%0d expected=2", e.tag, (cyc + 1) - e.acc);
                        end
                    end
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic drive(input bit s, input int e, input logic [47:0] m,
                         input bit z, input bit i, input bit n);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = 10'(e);
        in_mant  = m;
        in_zero  = z;
        in_inf   = i;
        in_nan   = n;
    endtask

    task automatic wait_accept(input logic [31:0] r, input logic [3:0] f, input bit lat);
        exp_t e;
        bit   done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = r; e.flg = f; e.acc = cyc + 1; e.lat = lat; e.tag = tag_cnt;
                tag_cnt++;
                q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tag=%0d got in_ready=0 expected in_ready=1", tag_cnt);
        end
    endtask

    task automatic issue(input bit s, input int e, input logic [47:0] m,
                         input bit z, input bit i, input bit n,
                         input logic [31:0] r, input logic [3:0] f, input bit lat);
        @(posedge clk); #2;
        drive(s, e, m, z, i, n);
        wait_accept(r, f, lat);
    endtask

    task automatic idle_in();
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_out", out, 32'd0);
        check_val("reset_flags", {28'd0, out_flags}, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Single operand into an empty pipeline, latency checked
        issue(0, 133, 48'h8B051EC00000, 0, 0, 0, 32'h430B051F, 4'b0001, 1);
        idle_in();
        repeat (3) @(posedge clk);

        // Back-to-back directed stream
        issue(0, 127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 4'b0001, 0);
        issue(0, 127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 4'b0001, 0);
        issue(0, 127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 4'b0001, 0);
        issue(0, 127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 4'b0000, 0);
        issue(0, 127, 48'h800000000000, 0, 0, 0, 32'h40000000, 4'b0000, 0);
        issue(0, 300, 48'h400000000000, 0, 0, 0, 32'h7F800000, 4'b0101, 0);
        issue(1, -10, 48'h400000000000, 0, 0, 0, 32'h80000000, 4'b0011, 0);
        issue(0, 254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 4'b0101, 0);
        issue(0, 253, 48'h800000000000, 0, 0, 0, 32'h7F000000, 4'b0000, 0);
        issue(0, 0,   48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011, 0);
        issue(1, 1,   48'h400000000000, 0, 0, 0, 32'h80800000, 4'b0000, 0);
        issue(0, 127, 48'h0,            0, 0, 1, 32'h7FC00000, 4'b0000, 0);
        issue(1, 127, 48'h0,            1, 1, 0, 32'h7FC00000, 4'b1000, 0);
        issue(1, 127, 48'h0,            0, 1, 0, 32'hFF800000, 4'b0000, 0);
        issue(1, 127, 48'h0,            1, 0, 0, 32'h80000000, 4'b0000, 0);
        idle_in();
        repeat (4) @(posedge clk);

        // Backpressure: two accepts fill the pipe, then in_ready must stay low
        #2 out_ready = 1'b0;
        issue(0, 127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 4'b0000, 0);
        issue(0, 128, 48'h400000000000, 0, 0, 0, 32'h40000000, 4'b0000, 0);
        @(posedge clk); #2;
        drive(0, 129, 48'h400000000000, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_accept(32'h40800000, 4'b0000, 0);
        issue(0, 130, 48'h400000000000, 0, 0, 0, 32'h41000000, 4'b0000, 0);
        idle_in();
        repeat (6) @(posedge clk);

        // Reset with both stages full
        #2 out_ready = 1'b0;
        issue(0, 127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 4'b0000, 0);
        issue(0, 128, 48'h400000000000, 0, 0, 0, 32'h40000000, 4'b0000, 0);
        idle_in();
        @(negedge clk);
        check_val("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_out", out, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #2;
        out_ready = 1'b1;
        issue(0, 127, 48'h600000000000, 0, 0, 0, 32'h3FC00000, 4'b0000, 1);
        idle_in();

        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got pending=%0d expected pending=0", q.size());
        end
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_round_norm.md
Name: fp_mul_round_norm

Overview:
- Downstream back-end of the single-precision floating-point multiplier datapath.
- Consumes the raw sign, unbiased-sum exponent, 48-bit significand product and special-case flags produced by the multiplier core.
- Produces a normalised, round-to-nearest-even IEEE-754 single result plus exception flags.
- 2-stage pipeline with valid/ready handshake on both sides; 1 result/cycle throughput.

Parameters:
- EXP_W, 10, width of signed two's-complement input exponent (must cover -125..381).
- QNAN, 32'h7FC00000, canonical NaN pattern emitted for any NaN/invalid result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept this cycle.
- in_sign  input  1  product sign (signA ^ signB).
- in_exp  input  EXP_W  signed biased exponent eA+eB-127.
- in_mant  input  48  24x24 significand product, hidden bits included.
- in_zero  input  1  either operand is zero.
- in_inf  input  1  either operand is infinity.
- in_nan  input  1  either operand is NaN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts this cycle.
- out  output  32  IEEE-754 single result.
- out_flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (rst_n=0 at clk edge): both stage valids cleared, out_valid=0, out=0, out_flags=0, in_ready=1 the cycle after reset. In-flight data discarded, no partial output.
- Handshake: transfer on valid&&ready. Stage k advances when its successor is empty or consumes; in_ready = !s1_valid || s1_advance (combinational from out_ready). out/out_flags held stable while out_valid&&!out_ready. No bubbles under continuous flow.
- Latency: accepted at edge N -> out_valid at edge N+2 when out_ready held high.
- Stage 1 (normalise):
  - If in_mant[47]: sig=in_mant[47:24], G=bit23, S=|[22:0], exp=in_exp+1.
  - Else: sig=in_mant[46:23], G=bit22, S=|[21:0], exp=in_exp.
  - Special flags registered unchanged.
- Stage 2 (round/pack):
  - RNE: round up iff G && (S || sig[0]); 25-bit add. Carry-out -> sig=24'h800000, exp+1.
  - inexact = G||S for finite non-zero results.
- Range (after rounding):
  - exp >= 255 -> {sign, 8'hFF, 23'd0}, overflow=1, inexact=1.
  - exp <= 0 -> {sign, 31'd0} (flush-to-zero; no denormals produced), underflow=1, inexact=1.
  - Otherwise {sign, exp[7:0], sig[22:0]}.
- Special priority (overrides arithmetic, all other flags 0):
  1. in_nan -> QNAN.
  2. in_inf && in_zero -> QNAN, invalid=1.
  3. in_inf -> {sign, 8'hFF, 23'd0}.
  4. in_zero -> {sign, 31'd0}.
- in_mant with both [47] and [46] clear is only legal when a special flag is set; otherwise result undefined (bench must not drive it).

Test Plan:
- 1.5*92.68: sign=0, exp=133, mant=48'h8B051EC00000 -> out=32'h430B051F, flags=4'b0001, out_valid exactly 2 cycles after accept.
- RNE ties, exp=127: mant=48'h400000C00000 -> 32'h3F800002; mant=48'h400000400000 -> 32'h3F800000; both inexact=1. Carry: mant=48'h7FFFFFC00000 -> 32'h40000000.
- Range: exp=300, mant=48'h400000000000, sign=0 -> 32'h7F800000, flags=4'b0101. exp=-10, sign=1 -> 32'h80000000, flags=4'b0011.
- Specials: nan -> 32'h7FC00000/4'b0000; inf&zero, sign=1 -> 32'h7FC00000/4'b1000; inf, sign=1 -> 32'hFF800000; zero, sign=1 -> 32'h80000000.
- Backpressure: stream 4 distinct operands, hold out_ready=0 for 5 cycles. in_ready drops after 2 accepts. out stable and unchanged while stalled. Release: all 4 results emitted in order, none dropped or duplicated.
- Reset mid-flight: rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, out=0, in_ready=1. The following operand completes normally.
